lut_mult_sequencer: RTL and testbench
=====================================

LUT_MULT_SEQUENCER -- requirements
Module: lut_mult_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit nibbles per operand; the block shall support values 1..4.
REQ-002 Parameter ACC_W, default 21: accumulator and result width in bits.
REQ-003 Port clk, input, 1 bit: single clock; all state shall update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 Port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 Port op_a, input, 4*NIBBLES bits: operand A.
REQ-008 Port op_b, input, 4*NIBBLES bits: operand B.
REQ-009 Port comp1, output, 4 bits: LUT operand 1, taken from nibble i of A.
REQ-010 Port comp2, output, 4 bits: LUT operand 2, taken from nibble j of B.
REQ-011 Port i, output, 3 bits: LUT index i.
REQ-012 Port j, output, 3 bits: LUT index j.
REQ-013 Port data, input, 17 bits: LUT result, registered, valid 1 cycle after comp1/comp2/i/j.
REQ-014 Port out_valid, output, 1 bit: result is valid.
REQ-015 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-016 Port result, output, ACC_W bits: accumulated sum of LUT results.
REQ-017 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 The FSM shall have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE: in_ready shall be 1; when in_valid=1, the block shall capture op_a/op_b, clear the accumulator, set the index to k=0 and go to ISSUE.
REQ-020 in_ready shall be 0 in every state other than IDLE; in_valid outside IDLE shall be ignored.
REQ-021 Operand changes after acceptance shall have no effect on the product in flight.
REQ-022 ISSUE: in each cycle the block shall drive i = k / NIBBLES and j = k % NIBBLES, with comp1 = A[4i+3:4i] and comp2 = B[4j+3:4j].
REQ-023 ISSUE: k shall increment each cycle; i is the outer index and j the inner index.
REQ-024 After the issue with k = NIBBLES^2-1, the FSM shall go to DRAIN.
REQ-025 Outside ISSUE, comp1, comp2, i and j shall be driven to 0.
REQ-026 A one-bit pending flag shall track each issue, delayed by one cycle.
REQ-027 In every cycle where the pending flag is 1, the accumulator shall add the zero-extended data.
REQ-028 Accumulator additions shall wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-029 The block shall not shift data itself; alignment is the LUT's responsibility.
REQ-030 DRAIN shall last exactly 1 cycle, during which the last data is added; the FSM shall then go to DONE.
REQ-031 DONE: out_valid shall be 1 and result shall equal the accumulator, both held stable until out_ready=1.
REQ-032 On the cycle where out_valid and out_ready are both 1, the FSM shall return to IDLE and out_valid shall be 0 on the next cycle.
REQ-033 Latency: with the acceptance edge as cycle 0, out_valid shall first be high in cycle NIBBLES^2+1 (cycle 17 at the default).
REQ-034 Throughput: at least one IDLE cycle shall separate consecutive operations.
REQ-035 out_ready while out_valid=0 shall have no effect.

Reset
REQ-036 When rst=1 at a clock edge, the FSM shall go to IDLE regardless of state, including mid-ISSUE, DRAIN or DONE.
REQ-037 On that edge, k, the pending flag and the accumulator shall be cleared.
REQ-038 On that edge, out_valid, result, busy, comp1, comp2, i and j shall be set to 0, and in_ready shall be 1 after the edge.
REQ-039 LUT data arriving in the cycle after reset shall be discarded, because the pending flag is 0.
REQ-040 rst shall take priority over in_valid and out_ready in the same cycle.

Verification
REQ-041 Bench with a stub LUT returning a constant 1 at 1-cycle latency; op_a=16'hFFFF, op_b=16'h1234 -> (i,j) sequence (0,0),(0,1)..(3,3) over 16 cycles with comp2 following 4,3,2,1, result=16, out_valid first in cycle 17.
REQ-042 Stub LUT returning comp1*comp2; op_a=16'h0021, op_b=16'h0003 -> result = 1*3 + 2*3 = 9, and every other term is 0.
REQ-043 Back-pressure: out_ready held at 0 for 5 cycles in DONE -> out_valid and result stay stable and in_ready stays 0; out_ready=1 -> IDLE on the next cycle.
REQ-044 rst asserted in ISSUE at k=7 -> the next cycle shows IDLE, busy=0, out_valid=0 and result=0; a new operation then completes with the correct value and no residue from the aborted one.
REQ-045 in_valid toggled and op_a changed during ISSUE -> the changes are ignored and the result matches the originally accepted operands.
REQ-046 NIBBLES=1 build: op_a=4'h5, op_b=4'h7 with stub comp1*comp2 -> result=35, out_valid in cycle 2.

Source files
------------

// File: rtl/lut_mult_sequencer.sv
// Sequences an NIBBLES x NIBBLES partial-product walk through an external registered LUT
// and accumulates the returned terms into a single result with a valid/ready handshake.
module lut_mult_sequencer #(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned ACC_W   = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic [3:0]             comp1,
    output logic [3:0]             comp2,
    output logic [2:0]             i,
    output logic [2:0]             j,
    input  logic [16:0]            data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       result,
    output logic                   busy
);

    localparam int unsigned OpW = 4 * NIBBLES;
    localparam logic [2:0] Last = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

    state_t           state;
    logic [OpW-1:0]   a_q;
    logic [OpW-1:0]   b_q;
    logic             pending;
    logic [ACC_W-1:0] acc;

    function automatic logic [3:0] nib(input logic [OpW-1:0] v, input logic [2:0] idx);
        logic [OpW-1:0] s;
        s = v >> {idx, 2'b00};
        return s[3:0];
    endfunction

    // i/j double as the k counter: j is the inner index, i the outer one. They are
    // only non-zero while in ISSUE, so they drive the LUT index ports directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            pending   <= 1'b0;
            acc       <= '0;
            comp1     <= '0;
            comp2     <= '0;
            i         <= '0;
            j         <= '0;
            out_valid <= 1'b0;
        end else begin
            pending <= (state == StIssue);
            if (pending) begin
                acc <= acc + ACC_W'(data);
            end
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        comp1 <= op_a[3:0];
                        comp2 <= op_b[3:0];
                        state <= StIssue;
                    end
                end
                StIssue: begin
                    if (i == Last && j == Last) begin
                        i     <= '0;
                        j     <= '0;
                        comp1 <= '0;
                        comp2 <= '0;
                        state <= StDrain;
                    end else if (j == Last) begin
                        i     <= i + 3'd1;
                        j     <= '0;
                        comp1 <= nib(a_q, i + 3'd1);
                        comp2 <= b_q[3:0];
                    end else begin
                        j     <= j + 3'd1;
                        comp2 <= nib(b_q, j + 3'd1);
                    end
                end
                StDrain: begin
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);
    assign result   = acc;

endmodule

// File: tb/tb_lut_mult_sequencer.sv
// Directed/random bench for lut_mult_sequencer with stub LUTs and a digit-sum product model.
module tb_lut_mult_sequencer;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] op_a, op_b;
    logic [3:0]  comp1, comp2;
    logic [2:0]  i, j;
    logic [16:0] data;
    logic [20:0] result;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, busy_s;
    logic [3:0]  op_a_s, op_b_s;
    logic [3:0]  comp1_s, comp2_s;
    logic [2:0]  i_s, j_s;
    logic [16:0] data_s;
    logic [20:0] result_s;

    int lut_mode;
    int checks = 0;
    int failures = 0;

    lut_mult_sequencer #(.NIBBLES(4), .ACC_W(21)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .comp1(comp1), .comp2(comp2), .i(i), .j(j),
        .data(data), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .busy(busy)
    );

    lut_mult_sequencer #(.NIBBLES(1), .ACC_W(21)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .op_a(op_a_s), .op_b(op_b_s), .comp1(comp1_s), .comp2(comp2_s), .i(i_s), .j(j_s),
        .data(data_s), .out_valid(out_valid_s), .out_ready(out_ready_s), .result(result_s),
        .busy(busy_s)
    );

    // Stub LUTs with one cycle of latency.
    always @(posedge clk) begin
        data   <= (lut_mode == 0) ? 17'd1 : 17'(comp1) * 17'(comp2);
        data_s <= 17'(comp1_s) * 17'(comp2_s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sum over all (i,j) of a_i*b_j factors into (sum of A nibbles) * (sum of B nibbles).
    function automatic int dsum(input logic [15:0] v);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(v[4*k +: 4]);
        return s;
    endfunction

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        chk("ready_before_accept", {31'd0, in_ready}, 1);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input bit disturb);
        int exp;
        exp = (lut_mode == 0) ? N * N : dsum(a) * dsum(b);
        accept(a, b);
        // Now in cycle 0 (acceptance edge just passed).
        for (int c = 0; c < N * N; c++) begin
            chk("issue_i", 32'(i), c / N);
            chk("issue_j", 32'(j), c % N);
            chk("issue_comp1", 32'(comp1), 32'(a[4*(c/N) +: 4]));
            chk("issue_comp2", 32'(comp2), 32'(b[4*(c%N) +: 4]));
            chk("issue_in_ready", {31'd0, in_ready}, 0);
            chk("issue_out_valid", {31'd0, out_valid}, 0);
            if (disturb) begin
                in_valid = 1'($urandom_range(0, 1));
                op_a = 16'($urandom);
                op_b = 16'($urandom);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("drain_outputs", 32'({comp1, comp2, i, j}), 0);
        chk("drain_out_valid", {31'd0, out_valid}, 0);
        chk("drain_busy", {31'd0, busy}, 1);
        tick();
        chk("done_out_valid", {31'd0, out_valid}, 1);
        chk("done_result", 32'(result), exp);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_out_valid", {31'd0, out_valid}, 1);
            chk("hold_result", 32'(result), exp);
            chk("hold_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_out_valid", {31'd0, out_valid}, 0);
        chk("ret_in_ready", {31'd0, in_ready}, 1);
        chk("ret_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        in_valid = 0; out_ready = 0; op_a = 0; op_b = 0;
        in_valid_s = 0; out_ready_s = 0; op_a_s = 0; op_b_s = 0;
        lut_mode = 0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_idx", 32'({comp1, comp2, i, j}), 0);
        chk("rst_s_in_ready", {31'd0, in_ready_s}, 1);
        rst = 1'b0;
        tick();

        // Constant-1 LUT: 16 terms of 1.
        run_op(16'hFFFF, 16'h1234, 0, 0);

        // Product LUT: only nibble pairs with both non-zero contribute.
        lut_mode = 1;
        run_op(16'h0021, 16'h0003, 0, 0);

        // Back-pressure in DONE.
        run_op(16'($urandom), 16'($urandom), 5, 0);

        // out_ready without out_valid does nothing.
        out_ready = 1'b1;
        repeat (3) tick();
        chk("idle_out_ready_busy", {31'd0, busy}, 0);
        chk("idle_out_ready_valid", {31'd0, out_valid}, 0);
        out_ready = 1'b0;

        // Abort mid-ISSUE at k=7.
        accept(16'hFFFF, 16'hFFFF);
        repeat (7) tick();
        chk("abort_pre_i", 32'(i), 1);
        chk("abort_pre_j", 32'(j), 3);
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_out_valid", {31'd0, out_valid}, 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_in_ready", {31'd0, in_ready}, 1);
        chk("abort_idx", 32'({comp1, comp2, i, j}), 0);
        tick();
        chk("abort_discard", 32'(result), 0);
        run_op(16'h0102, 16'h0300, 0, 0);

        // Input changes during ISSUE are ignored.
        run_op(16'($urandom), 16'($urandom), 0, 1);

        for (int n = 0; n < 4; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Single-nibble build.
        op_a_s = 4'h5;
        op_b_s = 4'h7;
        in_valid_s = 1'b1;
        tick();
        in_valid_s = 1'b0;
        chk("s_c0_comp1", 32'(comp1_s), 5);
        chk("s_c0_comp2", 32'(comp2_s), 7);
        chk("s_c0_ij", 32'({i_s, j_s}), 0);
        tick();
        chk("s_c1_out_valid", {31'd0, out_valid_s}, 0);
        chk("s_c1_comp1", 32'(comp1_s), 0);
        tick();
        chk("s_c2_out_valid", {31'd0, out_valid_s}, 1);
        chk("s_c2_result", 32'(result_s), 35);
        out_ready_s = 1'b1;
        tick();
        out_ready_s = 1'b0;
        chk("s_ret_out_valid", {31'd0, out_valid_s}, 0);
        chk("s_ret_busy", {31'd0, busy_s}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
